// File: rtl/karatsuba_pkg.sv
// Shared widths, state encoding and payload types for the Karatsuba operand issuer.
package karatsuba_pkg;

    localparam int unsigned LIMB_W = 64;
    localparam int unsigned SUM_W  = 65;
    localparam int unsigned X_W    = 128;
    localparam int unsigned Y_W    = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } operand_t;

    typedef struct packed {
        logic [SUM_W-1:0] x1x0;
        logic [SUM_W-1:0] y1y0;
        logic [SUM_W-1:0] y2y0;
        logic [SUM_W-1:0] y2y1;
        logic [SUM_W-1:0] y3y0;
        logic [SUM_W-1:0] y3y1;
    } presum_t;

endpackage

// File: rtl/limb_presum.sv
// Combinational limb pre-sums: 64-bit limbs zero-extended to 65 bits, never truncated.
module limb_presum
    import karatsuba_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output presum_t        sums
);

    function automatic logic [SUM_W-1:0] add_limbs(input logic [LIMB_W-1:0] a,
                                                   input logic [LIMB_W-1:0] b);
        return SUM_W'(a) + SUM_W'(b);
    endfunction

    logic [LIMB_W-1:0] x0, x1, y0, y1, y2, y3;

    assign x0 = x[0*LIMB_W +: LIMB_W];
    assign x1 = x[1*LIMB_W +: LIMB_W];
    assign y0 = y[0*LIMB_W +: LIMB_W];
    assign y1 = y[1*LIMB_W +: LIMB_W];
    assign y2 = y[2*LIMB_W +: LIMB_W];
    assign y3 = y[3*LIMB_W +: LIMB_W];

    assign sums.x1x0 = add_limbs(x1, x0);
    assign sums.y1y0 = add_limbs(y1, y0);
    assign sums.y2y0 = add_limbs(y2, y0);
    assign sums.y2y1 = add_limbs(y2, y1);
    assign sums.y3y0 = add_limbs(y3, y0);
    assign sums.y3y1 = add_limbs(y3, y1);

endmodule

// File: rtl/karatsuba_operand_issuer.sv
// Registers X/Y operand pairs plus limb pre-sums and issues them to the folded
// Karatsuba multiplier, holding them until completion with a one-entry pending buffer.
module karatsuba_operand_issuer
    import karatsuba_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [X_W-1:0]   s_x,
    input  logic [Y_W-1:0]   s_y,
    output logic             in_valid,
    output logic [X_W-1:0]   X,
    output logic [Y_W-1:0]   Y,
    output logic [SUM_W-1:0] X1X0,
    output logic [SUM_W-1:0] Y1Y0,
    output logic [SUM_W-1:0] Y2Y0,
    output logic [SUM_W-1:0] Y2Y1,
    output logic [SUM_W-1:0] Y3Y0,
    output logic [SUM_W-1:0] Y3Y1,
    input  logic             mul_out_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] issued_count
);

    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    operand_t          op_q, pend_q, src;
    presum_t           sums_q, src_sums;
    logic              pend_full;
    logic [WCNT_W-1:0] wait_cnt;
    logic              hs, load_out, from_pend, pend_wr, pend_clr, timeout_set, expired;

    assign s_ready = (state == IDLE) || !pend_full;
    assign hs      = s_valid && s_ready;
    assign expired = (wait_cnt == WCNT_W'(MAX_WAIT - 1));

    // Next-state and register-load decisions; a timeout retires the pair like a completion.
    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        from_pend   = 1'b0;
        pend_wr     = 1'b0;
        pend_clr    = 1'b0;
        timeout_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    load_out  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                pend_wr   = hs;
            end
            WAIT: begin
                if (mul_out_valid || expired) begin
                    timeout_set = !mul_out_valid;
                    if (pend_full) begin
                        load_out  = 1'b1;
                        from_pend = 1'b1;
                        pend_clr  = 1'b1;
                        state_nxt = ISSUE;
                    end else if (hs) begin
                        load_out  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    pend_wr = hs;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src = '0;
        if (from_pend) begin
            src = pend_q;
        end else begin
            src.x = s_x;
            src.y = s_y;
        end
    end

    limb_presum u_presum (
        .x    (src.x),
        .y    (src.y),
        .sums (src_sums)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= '0;
            sums_q       <= '0;
            pend_q       <= '0;
            pend_full    <= 1'b0;
            wait_cnt     <= '0;
            in_valid     <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
        end else begin
            state    <= state_nxt;
            in_valid <= (state_nxt == ISSUE);
            busy     <= (state_nxt != IDLE);
            wait_cnt <= (state == WAIT) ? wait_cnt + WCNT_W'(1) : '0;
            if (load_out) begin
                op_q   <= src;
                sums_q <= src_sums;
            end
            if (pend_clr) begin
                pend_full <= 1'b0;
            end else if (pend_wr) begin
                pend_full <= 1'b1;
                pend_q.x  <= s_x;
                pend_q.y  <= s_y;
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (state_nxt == ISSUE) begin
                issued_count <= issued_count + CNT_W'(1);
            end
        end
    end

    assign X    = op_q.x;
    assign Y    = op_q.y;
    assign X1X0 = sums_q.x1x0;
    assign Y1Y0 = sums_q.y1y0;
    assign Y2Y0 = sums_q.y2y0;
    assign Y2Y1 = sums_q.y2y1;
    assign Y3Y0 = sums_q.y3y0;
    assign Y3Y1 = sums_q.y3y1;

endmodule

// File: tb/tb_karatsuba_operand_issuer.sv
// Directed bench for karatsuba_operand_issuer: scoreboard of issued pairs, plus a
// second instance with a short MAX_WAIT for the timeout path.
module tb_karatsuba_operand_issuer;
    import karatsuba_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance (default MAX_WAIT)
    logic             reset, s_valid, s_ready, in_valid, mul_out_valid, busy, timeout_err;
    logic [X_W-1:0]   s_x, X;
    logic [Y_W-1:0]   s_y, Y;
    logic [SUM_W-1:0] X1X0, Y1Y0, Y2Y0, Y2Y1, Y3Y0, Y3Y1;
    logic [15:0]      issued_count;

    // timeout instance (MAX_WAIT = 8)
    logic             t_reset, t_s_valid, t_s_ready, t_in_valid, t_mul_out_valid, t_busy, t_timeout_err;
    logic [X_W-1:0]   t_s_x, t_X;
    logic [Y_W-1:0]   t_s_y, t_Y;
    logic [SUM_W-1:0] t_X1X0, t_Y1Y0, t_Y2Y0, t_Y2Y1, t_Y3Y0, t_Y3Y1;
    logic [15:0]      t_issued_count;

    karatsuba_operand_issuer #(.MAX_WAIT(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .in_valid(in_valid), .X(X), .Y(Y),
        .X1X0(X1X0), .Y1Y0(Y1Y0), .Y2Y0(Y2Y0), .Y2Y1(Y2Y1), .Y3Y0(Y3Y0), .Y3Y1(Y3Y1),
        .mul_out_valid(mul_out_valid), .busy(busy), .timeout_err(timeout_err),
        .issued_count(issued_count)
    );

    karatsuba_operand_issuer #(.MAX_WAIT(8), .CNT_W(16)) dut_to (
        .clock(clock), .reset(t_reset), .s_valid(t_s_valid), .s_ready(t_s_ready),
        .s_x(t_s_x), .s_y(t_s_y), .in_valid(t_in_valid), .X(t_X), .Y(t_Y),
        .X1X0(t_X1X0), .Y1Y0(t_Y1Y0), .Y2Y0(t_Y2Y0), .Y2Y1(t_Y2Y1), .Y3Y0(t_Y3Y0), .Y3Y1(t_Y3Y1),
        .mul_out_valid(t_mul_out_valid), .busy(t_busy), .timeout_err(t_timeout_err),
        .issued_count(t_issued_count)
    );

    int       n_assert = 0;
    int       n_fail   = 0;
    int       exp_cnt  = 0;
    operand_t sb[$];

    function automatic presum_t model(input logic [127:0] x, input logic [255:0] y);
        presum_t p;
        p.x1x0 = {1'b0, x[127:64]}  + {1'b0, x[63:0]};
        p.y1y0 = {1'b0, y[127:64]}  + {1'b0, y[63:0]};
        p.y2y0 = {1'b0, y[191:128]} + {1'b0, y[63:0]};
        p.y2y1 = {1'b0, y[191:128]} + {1'b0, y[127:64]};
        p.y3y0 = {1'b0, y[255:192]} + {1'b0, y[63:0]};
        p.y3y1 = {1'b0, y[255:192]} + {1'b0, y[127:64]};
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [127:0] rnd_x();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rnd_y();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one pair for one edge (optionally with completion) and record it as expected.
    task automatic drive(input logic [127:0] x, input logic [255:0] y, input logic done);
        operand_t o;
        chk("s_ready_at_offer", s_ready, 1);
        o.x = x;
        o.y = y;
        sb.push_back(o);
        s_valid = 1'b1; s_x = x; s_y = y; mul_out_valid = done;
        tick();
        s_valid = 1'b0; mul_out_valid = 1'b0;
    endtask

    // Called on the cycle in_valid must be high: pop the scoreboard and compare everything.
    task automatic check_issue(input string tag);
        operand_t e;
        presum_t  p;
        chk({tag, "_in_valid"}, in_valid, 1);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=pending pair", tag);
            return;
        end
        e = sb.pop_front();
        p = model(e.x, e.y);
        exp_cnt++;
        chk({tag, "_X"}, X, e.x);
        chk({tag, "_Y"}, Y, e.y);
        chk({tag, "_X1X0"}, X1X0, p.x1x0);
        chk({tag, "_Y1Y0"}, Y1Y0, p.y1y0);
        chk({tag, "_Y2Y0"}, Y2Y0, p.y2y0);
        chk({tag, "_Y2Y1"}, Y2Y1, p.y2y1);
        chk({tag, "_Y3Y0"}, Y3Y0, p.y3y0);
        chk({tag, "_Y3Y1"}, Y3Y1, p.y3y1);
        chk({tag, "_count"}, issued_count, exp_cnt);
    endtask

    task automatic complete();
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] ax, bx, tx;
        logic [255:0] ay, by, ty;
        presum_t      hp;

        reset = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; mul_out_valid = 1'b0;
        t_reset = 1'b1; t_s_valid = 1'b0; t_s_x = '0; t_s_y = '0; t_mul_out_valid = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_in_valid", in_valid, 0);
        chk("rst_X", X, 0);
        chk("rst_Y", Y, 0);
        chk("rst_X1X0", X1X0, 0);
        chk("rst_Y1Y0", Y1Y0, 0);
        chk("rst_Y3Y1", Y3Y1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_count", issued_count, 0);
        chk("rst_s_ready", s_ready, 1);
        reset = 1'b0;
        t_reset = 1'b0;
        tick();

        // single issue with known sums; completion during ISSUE must be ignored
        ax = '1;
        ay = 256'h92e5c273477d21d8_361651a6eea3cb5b_1c424d77f1b750a9_9cc6df2b0ee713a2;
        drive(ax, ay, 1'b0);
        check_issue("single");
        chk("single_X1X0_const", X1X0, 65'h1fffffffffffffffe);
        chk("single_Y1Y0_const", Y1Y0, 65'h0b9092ca3009e644b);
        chk("single_Y2Y0_const", Y2Y0, 65'h0d2dd30d1fd8adefd);
        chk("single_Y2Y1_const", Y2Y1, 65'h052589f1ee05b1c04);
        chk("single_Y3Y0_const", Y3Y0, 65'h12faca19e5664357a);
        chk("single_Y3Y1_const", Y3Y1, 65'h0af280feb39347281);
        chk("single_count_const", issued_count, 1);
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
        chk("single_strobe_len", in_valid, 0);
        chk("stale_done_ignored_busy", busy, 1);
        complete();
        chk("single_done_busy", busy, 0);
        chk("single_done_s_ready", s_ready, 1);

        // back-to-back: second pair parked in pending during WAIT
        ax = rnd_x(); ay = rnd_y(); bx = rnd_x(); by = rnd_y();
        drive(ax, ay, 1'b0);
        check_issue("b2b_a");
        tick();
        drive(bx, by, 1'b0);
        chk("b2b_pend_s_ready", s_ready, 0);
        chk("b2b_pend_in_valid", in_valid, 0);
        chk("b2b_pend_hold_X", X, ax);
        tick();
        chk("b2b_pend_s_ready2", s_ready, 0);
        complete();
        check_issue("b2b_b");
        chk("b2b_after_s_ready", s_ready, 1);
        tick();
        complete();
        chk("b2b_idle_busy", busy, 0);

        // handshake and completion in the same WAIT cycle, pending empty: no bubble
        ax = rnd_x(); ay = rnd_y(); bx = rnd_x(); by = rnd_y();
        drive(ax, ay, 1'b0);
        check_issue("direct_c");
        tick();
        drive(bx, by, 1'b1);
        check_issue("direct_d");
        tick();
        chk("direct_s_ready", s_ready, 1);
        complete();
        chk("direct_idle_busy", busy, 0);

        // hold stability over a 20-cycle wait
        ax = rnd_x(); ay = rnd_y();
        hp = model(ax, ay);
        drive(ax, ay, 1'b0);
        check_issue("hold");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_in_valid", in_valid, 0);
            chk("hold_X", X, ax);
            chk("hold_Y", Y, ay);
            chk("hold_X1X0", X1X0, hp.x1x0);
            chk("hold_Y2Y1", Y2Y1, hp.y2y1);
            chk("hold_Y3Y1", Y3Y1, hp.y3y1);
            chk("hold_busy", busy, 1);
        end
        complete();
        chk("hold_done_busy", busy, 0);
        chk("hold_no_timeout", timeout_err, 0);

        // completion while IDLE is ignored
        complete();
        chk("idle_done_in_valid", in_valid, 0);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_count", issued_count, exp_cnt);

        // timeout on the MAX_WAIT=8 instance
        tx = rnd_x(); ty = rnd_y();
        t_s_valid = 1'b1; t_s_x = tx; t_s_y = ty;
        tick();
        t_s_valid = 1'b0;
        chk("to_in_valid", t_in_valid, 1);
        chk("to_count1", t_issued_count, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_wait_err", t_timeout_err, 0);
            chk("to_wait_busy", t_busy, 1);
        end
        tick();
        chk("to_err_set", t_timeout_err, 1);
        chk("to_idle_busy", t_busy, 0);
        chk("to_idle_s_ready", t_s_ready, 1);

        // timeout with a pending pair moves straight to issuing it; error stays sticky
        t_s_valid = 1'b1; t_s_x = rnd_x(); t_s_y = rnd_y();
        tick();
        t_s_valid = 1'b0;
        chk("to_p_in_valid", t_in_valid, 1);
        tick();
        tx = rnd_x(); ty = rnd_y();
        t_s_valid = 1'b1; t_s_x = tx; t_s_y = ty;
        tick();
        t_s_valid = 1'b0;
        chk("to_q_pend_s_ready", t_s_ready, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        chk("to_q_still_wait", t_in_valid, 0);
        tick();
        chk("to_q_in_valid", t_in_valid, 1);
        chk("to_q_X", t_X, tx);
        chk("to_q_Y", t_Y, ty);
        chk("to_q_count", t_issued_count, 3);
        tick();
        t_mul_out_valid = 1'b1;
        tick();
        t_mul_out_valid = 1'b0;
        chk("to_sticky_err", t_timeout_err, 1);
        chk("to_q_done_busy", t_busy, 0);
        t_reset = 1'b1;
        tick();
        t_reset = 1'b0;
        chk("to_reset_err", t_timeout_err, 0);
        chk("to_reset_count", t_issued_count, 0);

        // reset mid-WAIT with pending full drops both pairs
        ax = rnd_x(); ay = rnd_y(); bx = rnd_x(); by = rnd_y();
        drive(ax, ay, 1'b0);
        check_issue("rstw_j");
        tick();
        drive(bx, by, 1'b0);
        chk("rstw_pend_s_ready", s_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_cnt = 0;
        chk("rstw_busy", busy, 0);
        chk("rstw_s_ready", s_ready, 1);
        chk("rstw_count", issued_count, 0);
        chk("rstw_in_valid", in_valid, 0);
        chk("rstw_X", X, 0);
        complete();
        chk("rstw_late_done_in_valid", in_valid, 0);
        tick();
        chk("rstw_late_done_in_valid2", in_valid, 0);
        chk("rstw_late_done_busy", busy, 0);
        chk("rstw_late_done_count", issued_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
